// File: rtl/dec_fpr_wb_ctl.sv
// Long-latency FP writeback controller: FIFO-buffered retire to FPR
// write port 2 plus a pending-write scoreboard for decode.
module dec_fpr_wb_ctl #(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          iss_valid,
  input  logic [4:0]    iss_rd,
  input  logic          flush,
  input  logic          dv_valid,
  input  logic [4:0]    dv_rd,
  input  logic [31:0]   dv_data,
  output logic          dv_ready,
  input  logic          ld_valid,
  input  logic [4:0]    ld_rd,
  input  logic [31:0]   ld_data,
  output logic          ld_ready,
  input  logic          wp_busy,
  output logic          wen2,
  output logic [4:0]    waddr2,
  output logic [31:0]   wd2,
  output logic [31:0]   pend,
  output logic [CW-1:0] occ
);

  localparam int AW = $clog2(DEPTH);

  logic [36:0]   mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [CW-1:0] occ_q, occ_d;
  logic          out_v_q, out_v_d;
  logic [4:0]    out_rd_q, out_rd_d;
  logic [31:0]   out_data_q, out_data_d;
  logic [31:0]   pend_q, pend_d;

  logic        full, empty;
  logic        acc_dv, acc_ld, acc;
  logic        adv, pop, byp, push;
  logic [36:0] in_ent, head;

  always_comb begin
    full     = (occ_q == CW'(DEPTH));
    empty    = (occ_q == '0);
    dv_ready = ~flush & ~full;
    ld_ready = ~flush & ~full & ~dv_valid;
    acc_dv   = dv_valid & dv_ready;
    acc_ld   = ld_valid & ld_ready;
    acc      = acc_dv | acc_ld;
    in_ent   = acc_dv ? {dv_rd, dv_data}
                      : {ld_rd, ld_data};
    head     = mem_q[rp_q];
    adv      = ~out_v_q | ~wp_busy;
    pop      = adv & ~empty;
    byp      = adv & empty & acc;
    push     = acc & ~byp;
    wen2     = out_v_q & ~wp_busy;
    waddr2   = out_rd_q;
    wd2      = out_data_q;
    pend     = pend_q;
    occ      = occ_q;
  end

  always_comb begin
    out_v_d    = out_v_q;
    out_rd_d   = out_rd_q;
    out_data_d = out_data_q;
    wp_d       = wp_q;
    rp_d       = rp_q;
    occ_d      = occ_q;
    if (adv) begin
      if (!empty) begin
        out_v_d    = 1'b1;
        out_rd_d   = head[36:32];
        out_data_d = head[31:0];
      end else if (acc) begin
        out_v_d    = 1'b1;
        out_rd_d   = in_ent[36:32];
        out_data_d = in_ent[31:0];
      end else begin
        out_v_d = 1'b0;
      end
    end
    if (push) wp_d = wp_q + AW'(1);
    if (pop)  rp_d = rp_q + AW'(1);
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + CW'(1);
      2'b01:   occ_d = occ_q - CW'(1);
      default: occ_d = occ_q;
    endcase
    if (flush) begin
      out_v_d = 1'b0;
      wp_d    = '0;
      rp_d    = '0;
      occ_d   = '0;
    end
  end

  // Set after clear: a same-cycle reissue to the retiring rd stays pending.
  always_comb begin
    pend_d = pend_q;
    if (wen2) pend_d[waddr2] = 1'b0;
    if (iss_valid) pend_d[iss_rd] = 1'b1;
    if (flush) pend_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q       <= '0;
      rp_q       <= '0;
      occ_q      <= '0;
      out_v_q    <= 1'b0;
      out_rd_q   <= '0;
      out_data_q <= '0;
      pend_q     <= '0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      occ_q      <= occ_d;
      out_v_q    <= out_v_d;
      out_rd_q   <= out_rd_d;
      out_data_q <= out_data_d;
      pend_q     <= pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= in_ent;
  end

endmodule

// File: tb/tb_dec_fpr_wb_ctl.sv
// Directed bench for dec_fpr_wb_ctl: hand-computed vectors
// plus an in-order stream checked against an expected queue.
module tb_dec_fpr_wb_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        flush;
  logic        dv_valid;
  logic [4:0]  dv_rd;
  logic [31:0] dv_data;
  logic        dv_ready;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        wp_busy;
  logic        wen2;
  logic [4:0]  waddr2;
  logic [31:0] wd2;
  logic [31:0] pend;
  logic [2:0]  occ;

  int n_chk = 0;
  int n_err = 0;

  logic [36:0] expq [$];
  logic [36:0] ent;
  int sent, rcvd;

  dec_fpr_wb_ctl #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .flush(flush),
    .dv_valid(dv_valid), .dv_rd(dv_rd),
    .dv_data(dv_data), .dv_ready(dv_ready),
    .ld_valid(ld_valid), .ld_rd(ld_rd),
    .ld_data(ld_data), .ld_ready(ld_ready),
    .wp_busy(wp_busy),
    .wen2(wen2), .waddr2(waddr2), .wd2(wd2),
    .pend(pend), .occ(occ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_valid = 0; iss_rd = 0; flush = 0;
    dv_valid = 0; dv_rd = 0; dv_data = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0;
  endtask

  initial begin
    idle();
    wp_busy = 0;
    rst = 1;
    #2;
    chk("rst_wen2", wen2, 0);
    chk("rst_waddr2", waddr2, 0);
    chk("rst_wd2", wd2, 0);
    chk("rst_pend", pend, 0);
    chk("rst_occ", occ, 0);
    chk("rst_dv_ready", dv_ready, 1);
    chk("rst_ld_ready0", ld_ready, 1);
    dv_valid = 1;
    #1;
    chk("rst_ld_ready1", ld_ready, 0);
    dv_valid = 0;
    @(negedge clk);
    rst = 0;
    step();

    // single divide, empty bypass
    dv_valid = 1; dv_rd = 5; dv_data = 32'h3F800000;
    #1;
    chk("div_ready", dv_ready, 1);
    step();
    idle();
    #1;
    chk("div_wen2", wen2, 1);
    chk("div_waddr2", waddr2, 5);
    chk("div_wd2", wd2, 32'h3F800000);
    chk("div_occ", occ, 0);
    step();
    chk("div_done", wen2, 0);

    // simultaneous sources, divide wins
    dv_valid = 1; dv_rd = 1; dv_data = 32'hAAAA0001;
    ld_valid = 1; ld_rd = 2; ld_data = 32'hBBBB0002;
    #1;
    chk("sim_dv_ready", dv_ready, 1);
    chk("sim_ld_ready", ld_ready, 0);
    step();
    dv_valid = 0;
    #1;
    chk("sim_wen_a", wen2, 1);
    chk("sim_addr_a", waddr2, 1);
    chk("sim_data_a", wd2, 32'hAAAA0001);
    chk("sim_ld_ready2", ld_ready, 1);
    step();
    idle();
    #1;
    chk("sim_wen_b", wen2, 1);
    chk("sim_addr_b", waddr2, 2);
    chk("sim_data_b", wd2, 32'hBBBB0002);
    step();
    chk("sim_done", wen2, 0);

    // backpressure: 1 in output reg + 4 in FIFO
    wp_busy = 1;
    for (int i = 0; i < 5; i++) begin
      ld_valid = 1; ld_rd = 5'(10 + i);
      ld_data = 32'h100 + i;
      #1;
      chk("bp_ld_ready", ld_ready, 1);
      step();
    end
    #1;
    chk("bp_occ", occ, 4);
    chk("bp_ld_full", ld_ready, 0);
    chk("bp_dv_full", dv_ready, 0);
    chk("bp_wen_busy", wen2, 0);
    ld_valid = 0;
    wp_busy = 0;
    #1;
    chk("bp_no_same_pop", ld_ready, 0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_wen", wen2, 1);
      chk("bp_addr", waddr2, 10 + i);
      chk("bp_data", wd2, 32'h100 + i);
      step();
      if (i == 0) chk("bp_ready_after", ld_ready, 1);
    end
    chk("bp_drain_wen", wen2, 0);
    chk("bp_drain_occ", occ, 0);

    // scoreboard
    iss_valid = 1; iss_rd = 7;
    step();
    iss_valid = 0;
    #1;
    chk("sb_set7", pend, 32'h80);
    dv_valid = 1; dv_rd = 7; dv_data = 32'h7;
    step();
    dv_valid = 0;
    #1;
    chk("sb_ret7_wen", wen2, 1);
    step();
    chk("sb_clr7", pend, 0);
    iss_valid = 1; iss_rd = 9;
    step();
    iss_valid = 0;
    dv_valid = 1; dv_rd = 9; dv_data = 32'h9;
    #1;
    chk("sb_set9", pend, 32'h200);
    step();
    dv_valid = 0;
    iss_valid = 1; iss_rd = 9;
    #1;
    chk("sb_ret9_addr", waddr2, 9);
    step();
    iss_valid = 0;
    #1;
    chk("sb_keep9", pend, 32'h200);
    dv_valid = 1; dv_rd = 9;
    step();
    dv_valid = 0;
    step();
    chk("sb_clr9", pend, 0);
    iss_valid = 1; iss_rd = 1; step();
    iss_rd = 2; step();
    iss_rd = 8; step();
    iss_valid = 0;

    // flush with 3 queued
    wp_busy = 1;
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1; ld_rd = 5'(20 + i);
      ld_data = 32'h200 + i;
      step();
    end
    ld_valid = 0;
    #1;
    chk("fl_occ_pre", occ, 3);
    chk("fl_pend_pre", pend, 32'h106);
    flush = 1; wp_busy = 0;
    dv_valid = 1; ld_valid = 1;
    iss_valid = 1; iss_rd = 20;
    #1;
    chk("fl_dv_ready", dv_ready, 0);
    chk("fl_ld_ready", ld_ready, 0);
    chk("fl_wen2", wen2, 1);
    step();
    idle();
    #1;
    chk("fl_occ", occ, 0);
    chk("fl_pend", pend, 0);
    chk("fl_wen2_after", wen2, 0);
    step();

    // asynchronous reset mid-operation
    wp_busy = 1;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1; ld_rd = 5'(i); ld_data = i;
      step();
    end
    ld_valid = 0;
    #1;
    chk("ar_occ_pre", occ, 2);
    #1;
    rst = 1;
    wp_busy = 0;
    #1;
    chk("ar_occ", occ, 0);
    chk("ar_wen2", wen2, 0);
    #1;
    rst = 0;
    step();

    // wrap-around stream, toggling busy
    sent = 0;
    rcvd = 0;
    for (int c = 0; c < 200 && rcvd < 12; c++) begin
      wp_busy = (c % 3 == 1) || (c % 7 == 3);
      idle();
      if (sent < 12) begin
        if (sent % 2 == 0) begin
          dv_valid = 1; dv_rd = 5'(3 + sent);
          dv_data = 32'hC0DE0000 + sent;
        end else begin
          ld_valid = 1; ld_rd = 5'(3 + sent);
          ld_data = 32'h10AD0000 + sent;
        end
      end
      #1;
      if (wen2) begin
        if (expq.size() == 0) begin
          chk("wr_extra", 1, 0);
        end else begin
          ent = expq.pop_front();
          chk("wr_entry", {waddr2, wd2}, ent);
          rcvd++;
        end
      end
      if (dv_valid && dv_ready) begin
        expq.push_back({dv_rd, dv_data});
        sent++;
      end else if (ld_valid && ld_ready) begin
        expq.push_back({ld_rd, ld_data});
        sent++;
      end
      step();
    end
    idle();
    chk("wr_count", rcvd, 12);
    chk("wr_occ", occ, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
